prog_mod_counter: RTL and testbench
===================================

# prog_mod_counter

Parametrised, programmable-modulus counter that generalises the team's fixed mod-15 up-counter. It supports runtime limit, up/down and wrap/saturate modes, synchronous load, enable, and a clock prescaler. It also provides a terminal-count pulse and a sticky overflow flag. It is the standard event/timebase counter for library blocks and test benches.

## Interface
Parameters:
- WIDTH, 4: count width in bits.
- PRESCALE_W, 8: prescaler compare width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- en  in  1  count enable; low freezes count and prescaler.
- mode  in  2  counting mode, one of the package enum values UP, DOWN, UP_SAT, DOWN_SAT.
- limit  in  WIDTH  terminal value; legal count range is 0..limit.
- prescale  in  PRESCALE_W  a step occurs every prescale+1 enabled cycles.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  value to load.
- clear_ovf  in  1  clears the ovf flag.
- count  out  WIDTH  current count.
- tc  out  1  one-cycle terminal-count pulse.
- ovf  out  1  sticky overflow/saturation flag.

## Operation
- Reset to 0: count, tc, ovf and the internal prescaler count pre_cnt.
- Priority per edge: reset, then load, then step.

Prescaler:
- When en=1 and no load: if pre_cnt==prescale, a tick occurs and pre_cnt becomes 0; otherwise pre_cnt increments.
- prescale=0 gives a tick every enabled cycle.
- en=0 holds both pre_cnt and count; a pending tick is not lost or duplicated.

Load:
- count becomes min(load_val, limit) and pre_cnt becomes 0.
- tc becomes 0; ovf is unchanged.
- load overrides a same-cycle tick.

Step (on tick):
- UP: if count>=limit, count becomes 0 and tc=1; else count+1.
- DOWN: if count==0, count becomes limit and tc=1; else count-1.
- UP_SAT: if count<limit, count+1, with tc=1 when the new value equals limit; if count>=limit, count becomes limit and ovf=1.
- DOWN_SAT: if count>0, count-1, with tc=1 when the new value is 0; if count==0, hold and set ovf=1.

Flags:
- ovf is also set on every UP/DOWN wrap.
- clear_ovf clears ovf; if a set event occurs in the same cycle, set wins.
- tc is 0 in every cycle without a qualifying step.

Runtime changes:
- limit lowered below count: the next UP step wraps to 0 with tc; a DOWN step decrements normally.
- mode change takes effect at the next tick; no state is flushed.

Arithmetic: all arithmetic is WIDTH-bit unsigned; there is no internal overflow because compares precede the increment.

## Timing
- All outputs are registered. count, tc and ovf reflect a step on the clock edge at which the tick occurs.
- tc is high for exactly the one cycle in which count shows the wrapped or endpoint value.
- Latency from load to count is 1 cycle. Latency from en rising to the first step is prescale+1 cycles.
- reset or load asserted and deasserted between clock edges has no effect.
- Reset mid-count returns to the reset state at the next edge regardless of en or load.
- Default configuration (WIDTH=4, limit=14, UP, prescale=0, en=1) must be cycle-identical to the legacy mod-15 counter.

## Structure
- Package prog_counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_t {UP, DOWN, UP_SAT, DOWN_SAT};
  - default parameter constants.
- Sub-module tick_prescaler (PRESCALE_W) contains pre_cnt and the tick logic, with ports clk, reset, en, clr, prescale, tick.
- The top level holds the count/flag register and next-state logic.

## Test plan
- Free-run: reset, en=1, UP, limit=14, prescale=0, 17 edges. Required: count 0..14,0,1; tc high only while count=0 after 14; ovf=1.
- Prescale: prescale=2, limit=3. Required: count changes every 3rd cycle, 0,1,2,3,0; toggling en for 2 cycles delays the sequence by exactly 2.
- DOWN: limit=5, load_val=2. Required: count 2,1,0,5,4; tc with count=5.
- UP_SAT: limit=9, 11 ticks. Required: tc once at 9, count holds 9, ovf set on the 10th tick. clear_ovf with no event clears ovf; clear_ovf together with a saturating tick keeps ovf=1.
- Load: load_val=12 with limit=7 gives count=7; load together with a tick gives the loaded value; lowering limit to 3 while count=7 in UP gives count 0 and tc at the next tick.
- Reset: a 3 ns reset pulse between edges leaves count unchanged; reset held across an edge mid-count gives count=0, tc=0, ovf=0, and the next step occurs prescale+1 cycles later.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types and default sizing for the programmable-modulus counter.
package prog_counter_pkg;

    typedef enum logic [1:0] {UP, DOWN, UP_SAT, DOWN_SAT} cnt_mode_t;

    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles into ticks: one tick every prescale+1 enabled cycles.
module tick_prescaler
    import prog_counter_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pre_cnt;

    // clr (a load) suppresses the tick so the load alone defines the next count.
    assign tick = en && !clr && (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == prescale) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_ONE;
            end
        end
    end

endmodule

// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down counter with wrap or saturate modes, load,
// prescaled stepping, a terminal-count pulse and a sticky overflow flag.
module prog_mod_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  cnt_mode_t             mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clear_ovf,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             tick;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_set;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Limit compares come before any +/-1, so the WIDTH-bit arithmetic never wraps.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_set   = 1'b0;
        if (load) begin
            count_nxt = (load_val > limit) ? limit : load_val;
        end else if (tick) begin
            case (mode)
                UP: begin
                    if (count >= limit) begin
                        count_nxt = '0;
                        tc_nxt    = 1'b1;
                        ovf_set   = 1'b1;
                    end else begin
                        count_nxt = count + ONE;
                    end
                end
                DOWN: begin
                    if (count == '0) begin
                        count_nxt = limit;
                        tc_nxt    = 1'b1;
                        ovf_set   = 1'b1;
                    end else begin
                        count_nxt = count - ONE;
                    end
                end
                UP_SAT: begin
                    if (count < limit) begin
                        count_nxt = count + ONE;
                        tc_nxt    = ((count + ONE) == limit);
                    end else begin
                        count_nxt = limit;
                        ovf_set   = 1'b1;
                    end
                end
                default: begin
                    if (count != '0) begin
                        count_nxt = count - ONE;
                        tc_nxt    = (count == ONE);
                    end else begin
                        ovf_set   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            // A set event in the same cycle as clear_ovf wins.
            ovf   <= ovf_set | (ovf & ~clear_ovf);
        end
    end

endmodule

// File: tb/tb_prog_mod_counter.sv
// Self-checking bench for prog_mod_counter: per-cycle model scoreboard plus
// directed scenarios with hand-computed literal expectations.
module tb_prog_mod_counter;
    import prog_counter_pkg::*;

    localparam int WIDTH      = 4;
    localparam int PRESCALE_W = 8;
    localparam int W          = WIDTH + 2;

    logic                  clk;
    logic                  reset;
    logic                  en;
    cnt_mode_t             mode;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  clear_ovf;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    prog_mod_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .limit     (limit),
        .prescale  (prescale),
        .load      (load),
        .load_val  (load_val),
        .clear_ovf (clear_ovf),
        .count     (count),
        .tc        (tc),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int m_count = 0;
    int m_pre   = 0;
    bit m_tc    = 0;
    bit m_ovf   = 0;
    bit m_tick;
    bit m_set;
    int lim;

    always @(posedge clk) begin
        lim = int'(limit);
        if (reset) begin
            m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0;
        end else if (load) begin
            m_count = (int'(load_val) > lim) ? lim : int'(load_val);
            m_pre   = 0;
            m_tc    = 0;
            if (clear_ovf) m_ovf = 0;
        end else begin
            m_tick = 0;
            m_set  = 0;
            m_tc   = 0;
            if (en) begin
                if (m_pre == int'(prescale)) begin m_tick = 1; m_pre = 0; end
                else m_pre = m_pre + 1;
            end
            if (m_tick) begin
                case (mode)
                    UP:       if (m_count >= lim) begin m_count = 0; m_tc = 1; m_set = 1; end
                              else m_count = m_count + 1;
                    DOWN:     if (m_count == 0) begin m_count = lim; m_tc = 1; m_set = 1; end
                              else m_count = m_count - 1;
                    UP_SAT:   if (m_count < lim) begin m_count = m_count + 1; m_tc = (m_count == lim); end
                              else begin m_count = lim; m_set = 1; end
                    default:  if (m_count > 0) begin m_count = m_count - 1; m_tc = (m_count == 0); end
                              else m_set = 1;
                endcase
            end
            if (m_set) m_ovf = 1;
            else if (clear_ovf) m_ovf = 0;
        end
        exp_q.push_back({WIDTH'(m_count), m_tc, m_ovf});
    end

    // ---------------- scoreboard compare ----------------
    logic [W-1:0] exp_v;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            n_tests++;
            if ({count, tc, ovf} !== exp_v) begin
                n_fail++;
                $display("FAIL cycle@%0t: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                         $time, count, tc, ovf, exp_v[W-1:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; en = 1'b0; mode = UP; limit = 4'd14; prescale = '0;
        load = 1'b0; load_val = '0; clear_ovf = 1'b0;
        cyc(); cyc();
        chk("reset_count", 32'(count), 0);
        chk("reset_tc", 32'(tc), 0);
        chk("reset_ovf", 32'(ovf), 0);

        // Legacy mod-15 free run
        reset = 1'b0; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("freerun_count", 32'(count), i % 15);
            chk("freerun_tc", 32'(tc), (i == 15) ? 1 : 0);
        end
        chk("freerun_ovf", 32'(ovf), 1);

        // Prescale by 3, then en gap of 2 cycles
        limit = 4'd3; prescale = 8'd2;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("prescale_count", 32'(count), (k / 3) % 4);
        end
        cyc();
        en = 1'b0;
        cyc(); cyc();
        chk("en_hold_count", 32'(count), 0);
        en = 1'b1;
        cyc();
        chk("en_delay_count", 32'(count), 0);
        cyc();
        chk("en_step_count", 32'(count), 1);

        // DOWN wrap from 0 to limit
        mode = DOWN; limit = 4'd5; prescale = '0;
        do_reset();
        load = 1'b1; load_val = 4'd2;
        cyc();
        load = 1'b0;
        chk("down_load", 32'(count), 2);
        cyc(); chk("down_1", 32'(count), 1);
        cyc(); chk("down_0", 32'(count), 0); chk("down_0_tc", 32'(tc), 0);
        cyc(); chk("down_wrap", 32'(count), 5); chk("down_wrap_tc", 32'(tc), 1);
        cyc(); chk("down_4", 32'(count), 4); chk("down_4_tc", 32'(tc), 0);

        // UP_SAT with overflow and clear_ovf interplay
        mode = UP_SAT; limit = 4'd9;
        do_reset();
        for (int t = 1; t <= 11; t++) begin
            cyc();
            chk("sat_count", 32'(count), (t < 9) ? t : 9);
            chk("sat_tc", 32'(tc), (t == 9) ? 1 : 0);
            chk("sat_ovf", 32'(ovf), (t >= 10) ? 1 : 0);
        end
        en = 1'b0; clear_ovf = 1'b1;
        cyc();
        chk("clr_ovf_idle", 32'(ovf), 0);
        en = 1'b1;
        cyc();
        chk("clr_ovf_vs_set", 32'(ovf), 1);
        clear_ovf = 1'b0;

        // Load clamps, beats a tick, then limit lowered under count
        mode = UP; limit = 4'd7; en = 1'b0;
        load = 1'b1; load_val = 4'd12;
        cyc();
        chk("load_clamp", 32'(count), 7);
        chk("load_tc", 32'(tc), 0);
        en = 1'b1; load_val = 4'd3;
        cyc();
        chk("load_vs_tick", 32'(count), 3);
        en = 1'b0; load_val = 4'd7;
        cyc();
        chk("load_7", 32'(count), 7);
        load = 1'b0; limit = 4'd3; en = 1'b1;
        cyc();
        chk("limit_low_count", 32'(count), 0);
        chk("limit_low_tc", 32'(tc), 1);

        // Reset: short pulse between edges, then held across an edge
        limit = 4'd14; prescale = 8'd2; load = 1'b1; load_val = '0;
        cyc();
        load = 1'b0;
        repeat (4) cyc();
        chk("pre_pulse_count", 32'(count), 1);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        cyc();
        chk("pulse_ignored", 32'(count), 1);
        cyc();
        chk("pulse_step", 32'(count), 2);
        chk("pre_reset_ovf", 32'(ovf), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_tc", 32'(tc), 0);
        chk("midrst_ovf", 32'(ovf), 0);
        cyc(); cyc();
        chk("post_rst_wait", 32'(count), 0);
        cyc();
        chk("post_rst_step", 32'(count), 1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
